// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one synchronous FIFO write port among NUM_REQ producers.
// A grant is held until req_last or MAX_BURST accepted beats; arbitration takes one idle cycle.
module fifo_rr_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MAX_BURST = 4,
    localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    input  logic [CNT_W-1:0]            fifo_cnt,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_data,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] owner, owner_nxt;
    logic [ID_W-1:0] last_grant, last_grant_nxt;
    logic [3:0]      beat_cnt, beat_cnt_nxt;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] cand;
    logic            space_ok;
    logic            accept;

    // Scan last_grant+1 .. last_grant+NUM_REQ modulo NUM_REQ; first valid wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((32'(last_grant) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign space_ok = (fifo_cnt < CNT_W'(DEPTH));
    // A beat presented on a reset edge must not reach the FIFO.
    assign accept   = (state == BURST) && req_valid[owner] && !fifo_full && !rst;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        req_ready      = '0;
        fifo_wr        = 1'b0;
        fifo_data      = '0;
        case (state)
            IDLE: begin
                if (pick_found && space_ok) begin
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = BURST;
                end
            end
            BURST: begin
                req_ready[owner] = !fifo_full && !rst;
                fifo_data        = req_data[owner*DATA_W +: DATA_W];
                fifo_wr          = accept;
                if (accept) begin
                    beat_cnt_nxt = beat_cnt + 4'd1;
                    if (req_last[owner] || (beat_cnt == 4'(MAX_BURST - 1))) begin
                        last_grant_nxt = owner;
                        beat_cnt_nxt   = '0;
                        state_nxt      = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    assign busy     = (state == BURST);
    assign grant_id = owner;

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Directed bench for fifo_rr_wr_arbiter: reset, round robin, burst cap, full stall,
// no-space hold and mid-burst reset, each checked against hand-computed values.
module tb_fifo_rr_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic [3:0]  fifo_cnt;
    logic        fifo_wr;
    logic [7:0]  fifo_data;
    logic [1:0]  grant_id;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fifo_rr_wr_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .DEPTH(8), .CNT_W(4), .MAX_BURST(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_cnt(fifo_cnt),
        .fifo_wr(fifo_wr), .fifo_data(fifo_data),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_burst(input string tag, input logic [1:0] id, input logic wr,
                             input logic [7:0] data);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " grant"}, 32'(grant_id), 32'(id));
        chk({tag, " ready"}, 32'(req_ready), wr ? 32'(4'b0001 << id) : 32'd0);
        chk({tag, " wr"}, 32'(fifo_wr), 32'(wr));
        if (wr) chk({tag, " data"}, 32'(fifo_data), 32'(data));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " ready"}, 32'(req_ready), 32'd0);
        chk({tag, " wr"}, 32'(fifo_wr), 32'd0);
        chk({tag, " data"}, 32'(fifo_data), 32'd0);
    endtask

    logic [1:0] rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] rr_data [5] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};

    initial begin
        // T1: reset held with every requester valid
        rst = 1'b1; req_valid = 4'hF; req_last = 4'hF;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        fifo_full = 1'b0; fifo_cnt = 4'd0;
        cyc();
        chk_idle("t1_rst_a");
        chk("t1_rst_a grant", 32'(grant_id), 32'd0);
        cyc();
        chk_idle("t1_rst_b");
        rst = 1'b0;
        #1 chk_idle("t1_post_rst");
        cyc();

        // T2: all valid, single-beat packets -> 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            #1 chk_burst($sformatf("t2_beat%0d", k), rr_id[k], 1'b1, rr_data[k]);
            cyc();
            #1 chk_idle($sformatf("t2_idle%0d", k));
            if (k == 4) req_valid = 4'h0;
            cyc();
        end

        // T3: req 2 alone, 6 beats, cap splits them 4 + 2
        req_valid = 4'b0100; req_last = 4'h0; req_data = 32'h0;
        #1 chk_idle("t3_pre");
        cyc();
        for (int b = 0; b < 4; b++) begin
            req_data[23:16] = 8'hA0 + 8'(b);
            #1 chk_burst($sformatf("t3_beat%0d", b), 2'd2, 1'b1, 8'hA0 + 8'(b));
            cyc();
        end
        req_data[23:16] = 8'hA4;
        #1 chk_idle("t3_cap_idle");
        cyc();
        #1 chk_burst("t3_beat4", 2'd2, 1'b1, 8'hA4);
        cyc();
        req_data[23:16] = 8'hA5; req_last = 4'b0100;
        #1 chk_burst("t3_beat5", 2'd2, 1'b1, 8'hA5);
        cyc();
        req_valid = 4'h0; req_last = 4'h0;
        #1 chk_idle("t3_end");

        // T4: req 3, fifo_full for 3 cycles at beat 2
        req_valid = 4'b1000; req_data[31:24] = 8'hB0;
        cyc();
        #1 chk_burst("t4_beat0", 2'd3, 1'b1, 8'hB0);
        cyc();
        req_data[31:24] = 8'hB1;
        #1 chk_burst("t4_beat1", 2'd3, 1'b1, 8'hB1);
        cyc();
        req_data[31:24] = 8'hB2; fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1 chk_burst($sformatf("t4_stall%0d", s), 2'd3, 1'b0, 8'h00);
            cyc();
        end
        fifo_full = 1'b0;
        #1 chk_burst("t4_beat2", 2'd3, 1'b1, 8'hB2);
        cyc();
        req_data[31:24] = 8'hB3; req_last = 4'b1000;
        #1 chk_burst("t4_beat3", 2'd3, 1'b1, 8'hB3);
        cyc();
        req_valid = 4'h0; req_last = 4'h0;
        #1 chk_idle("t4_end");

        // T5: fifo_cnt at DEPTH blocks arbitration
        req_valid = 4'b0010; req_last = 4'b0010; req_data[15:8] = 8'h5C; fifo_cnt = 4'd8;
        cyc();
        #1 chk_idle("t5_hold_a");
        cyc();
        #1 chk_idle("t5_hold_b");
        fifo_cnt = 4'd7;
        #1 chk_idle("t5_release");
        cyc();
        #1 chk_burst("t5_grant", 2'd1, 1'b1, 8'h5C);
        cyc();
        req_valid = 4'h0; req_last = 4'h0; fifo_cnt = 4'd0;
        #1 chk_idle("t5_end");

        // T6: reset during beat 1 of req 3; next grant restarts at req 0
        req_valid = 4'b1000; req_data = {8'hC0, 8'h00, 8'h00, 8'hD0};
        cyc();
        #1 chk_burst("t6_beat0", 2'd3, 1'b1, 8'hC0);
        cyc();
        req_data[31:24] = 8'hC1; rst = 1'b1;
        #1 chk("t6_rst_wr", 32'(fifo_wr), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        cyc();
        rst = 1'b0; req_valid = 4'b1001;
        #1 chk_idle("t6_after_rst");
        chk("t6_after_rst grant", 32'(grant_id), 32'd0);
        cyc();
        #1 chk_burst("t6_regrant", 2'd0, 1'b1, 8'hD0);
        req_valid = 4'h0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
